// File: rtl/signed_dec_formatter_if.sv
// Handshake and digit-field bundle between a requester and signed_dec_formatter.
interface signed_dec_formatter_if #(
  parameter int W    = 10,
  parameter int NDIG = 6
);
  logic                 start;
  logic [W-1:0]         value;
  logic                 busy;
  logic                 done;
  logic [4*NDIG-1:0]    num;
  logic [NDIG-1:0]      sign;
  logic [NDIG-1:0]      off;

  modport master (output start, value, input busy, done, num, sign, off);
  modport slave  (input start, value, output busy, done, num, sign, off);
endinterface

// File: rtl/signed_dec_formatter.sv
// Two's-complement to per-digit decimal fields (digit code, minus, blank) for
// seven-segment drivers, using a multi-cycle double-dabble conversion.
module signed_dec_formatter #(
  parameter int W    = 10,
  parameter int NDIG = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  signed_dec_formatter_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * NDIG;

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // A sign position must always remain above the widest magnitude.
  if (W < 2 || W > 16) begin : g_bad_w
    $error("signed_dec_formatter: W must be in 2..16");
  end
  if (p10(NDIG - 1) <= (longint'(1) << (W - 1))) begin : g_bad_ndig
    $error("signed_dec_formatter: NDIG too small for a sign position");
  end

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, FORMAT} state_t;
  state_t state, state_n;

  logic [W-1:0]    val_q;
  logic            neg;
  logic [W-1:0]    mag;
  logic [BW-1:0]   bcd, bcd_adj;
  logic [CW-1:0]   cnt;
  logic            done_q;
  logic [BW-1:0]   num_q, num_f;
  logic [NDIG-1:0] sign_q, sign_f, off_q, off_f;
  int              m;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = ABS;
      ABS:     state_n = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_n = FORMAT;
      FORMAT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_q;
    bus.num  = num_q;
    bus.sign = sign_q;
    bus.off  = off_q;
  end

  for (genvar d = 0; d < NDIG; d++) begin : g_adj
    assign bcd_adj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3
                                                       : bcd[4*d +: 4];
  end

  // Magnitude is fully shifted out by FORMAT, so a zero BCD means zero value.
  always_comb begin
    m      = 0;
    num_f  = '0;
    sign_f = '0;
    off_f  = '0;
    for (int i = 0; i < NDIG; i++)
      if (bcd[4*i +: 4] != 4'd0) m = i;
    for (int i = 0; i < NDIG; i++) begin
      if (i <= m) num_f[4*i +: 4] = bcd[4*i +: 4];
      else        off_f[i] = 1'b1;
      if (neg && (bcd != '0) && (i == m + 1)) begin
        sign_f[i] = 1'b1;
        off_f[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q  <= '0;
      neg    <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      num_q  <= '0;
      sign_q <= '0;
      off_q  <= {{(NDIG-1){1'b1}}, 1'b0};
    end else begin
      done_q <= (state == FORMAT);
      case (state)
        IDLE: if (bus.start) val_q <= bus.value;
        ABS: begin
          neg <= val_q[W-1];
          mag <= val_q[W-1] ? (~val_q + W'(1)) : val_q;
          bcd <= '0;
          cnt <= CW'(W);
        end
        SHIFT: begin
          bcd <= {bcd_adj[BW-2:0], mag[W-1]};
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        FORMAT: begin
          num_q  <= num_f;
          sign_q <= sign_f;
          off_q  <= off_f;
        end
        default: ;
      endcase
    end
  end
endmodule
